// File: rtl/main_alu.sv
// main_alu: small sequenced ALU. A LOAD cycle captures the operand registers A/B,
// the following EXEC cycle writes the accumulator from a one-hot operation select.
// Optional feature: define OVERFLOW_TRAP_EN to trap unsigned add carry, sub borrow
// and multiply high bits (ACC forced to all ones, FSM enters ERR). The default build
// wraps modulo 2^WIDTH.
module main_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [6:0]       out_sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
);

    typedef enum logic [1:0] {
        StOff  = 2'b00,
        StLoad = 2'b01,
        StExec = 2'b10,
        StErr  = 2'b11
    } state_t;

    localparam logic [6:0] OpAdd = 7'b1000000;
    localparam logic [6:0] OpSub = 7'b0100000;
    localparam logic [6:0] OpMul = 7'b0010000;
    localparam logic [6:0] OpAnd = 7'b0001000;
    localparam logic [6:0] OpOr  = 7'b0000100;
    localparam logic [6:0] OpXor = 7'b0000010;
    localparam logic [6:0] OpNot = 7'b0000001;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result;
    logic             op_valid;
    logic             ovf;

`ifdef OVERFLOW_TRAP_EN
    logic [WIDTH:0]     add_full;
    logic [2*WIDTH-1:0] mul_full;
`endif

    // Exactly one bit of out_sel set; anything else is an invalid opcode.
    assign op_valid = (out_sel != 7'd0) && ((out_sel & (out_sel - 7'd1)) == 7'd0);

    // Operation datapath and overflow detection.
    always_comb begin
        result = acc_q;
        ovf    = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        add_full = {1'b0, a_q} + {1'b0, b_q};
        mul_full = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        case (out_sel)
            OpAdd: begin
                result = add_full[WIDTH-1:0];
                ovf    = add_full[WIDTH];
            end
            OpSub: begin
                result = a_q - b_q;
                ovf    = (a_q < b_q);
            end
            OpMul: begin
                result = mul_full[WIDTH-1:0];
                ovf    = (mul_full[2*WIDTH-1:WIDTH] != '0);
            end
            OpAnd:   result = a_q & b_q;
            OpOr:    result = a_q | b_q;
            OpXor:   result = a_q ^ b_q;
            OpNot:   result = ~a_q;
            default: result = acc_q;
        endcase
`else
        case (out_sel)
            OpAdd:   result = a_q + b_q;
            OpSub:   result = a_q - b_q;
            OpMul:   result = a_q * b_q;
            OpAnd:   result = a_q & b_q;
            OpOr:    result = a_q | b_q;
            OpXor:   result = a_q ^ b_q;
            OpNot:   result = ~a_q;
            default: result = acc_q;
        endcase
`endif
    end

    // Next-state and register next-values; on=0 overrides everything and holds data.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        if (!on) begin
            state_d = StOff;
        end else begin
            case (state_q)
                StOff: state_d = StLoad;
                StLoad: begin
                    state_d = StExec;
                    // Priority: clear > load > persist; 000 holds.
                    if (in_sel[0]) begin
                        a_d = '0;
                        b_d = '0;
                    end else if (in_sel[1]) begin
                        a_d = num1;
                        b_d = num2;
                    end else if (in_sel[2]) begin
                        a_d = acc_q;
                        b_d = num2;
                    end
                end
                StExec: begin
                    if (!op_valid) begin
                        state_d = StErr;
                    end else if (ovf) begin
                        acc_d   = '1;
                        state_d = StErr;
                    end else begin
                        acc_d   = result;
                        state_d = StLoad;
                    end
                end
                StErr:   state_d = StLoad;
                default: state_d = StOff;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign out       = acc_q;
    assign currState = state_q;
    assign nextState = state_d;

endmodule

// File: tb/tb_main_alu.sv
// Directed-vector bench for main_alu; expected values are hand computed.
module tb_main_alu;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             on;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [6:0]       out_sel;
    logic [WIDTH-1:0] out;
    logic [1:0]       currState;
    logic [1:0]       nextState;

    int checks = 0;
    int errors = 0;

    main_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; on = 1'b0; in_sel = 3'b000; num1 = '0; num2 = '0; out_sel = 7'b0;
        step();
        step();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
        checks++;
        if (currState !== 2'b00) begin
            errors++; $display("FAIL reset_state: got %b want 00", currState);
        end
        checks++;
        if (nextState !== 2'b00) begin
            errors++; $display("FAIL reset_next_off: got %b want 00", nextState);
        end
        on = 1'b1;
        #1;
        checks++;
        if (nextState !== 2'b01) begin
            errors++; $display("FAIL reset_next_on: got %b want 01", nextState);
        end
    endtask

    task automatic test_add_latency();
        in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b1000000;
        rst = 1'b0;
        step();
        checks++;
        if (currState !== 2'b01) begin errors++; $display("FAIL seq_load: got %b want 01", currState); end
        step();
        checks++;
        if (currState !== 2'b10) begin errors++; $display("FAIL seq_exec: got %b want 10", currState); end
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL early_out: got %h want 00", out); end
        step();
        checks++;
        if (currState !== 2'b01) begin errors++; $display("FAIL seq_back: got %b want 01", currState); end
        checks++;
        if (out !== 8'h71) begin errors++; $display("FAIL add_57_1a: got %h want 71", out); end
    endtask

    task automatic test_op_sweep();
        logic [6:0] sels [6];
        logic [7:0] exps [6];
        sels[0] = 7'b0100000; exps[0] = 8'h3D;
        sels[1] = 7'b0010000; exps[1] = 8'hD6;
        sels[2] = 7'b0001000; exps[2] = 8'h12;
        sels[3] = 7'b0000100; exps[3] = 8'h5F;
        sels[4] = 7'b0000010; exps[4] = 8'h4D;
        sels[5] = 7'b0000001; exps[5] = 8'hA8;
`ifdef OVERFLOW_TRAP_EN
        exps[1] = 8'hFF;
`endif
        for (int i = 0; i < 6; i++) begin
            out_sel = sels[i];
            step();
            step();
            checks++;
            if (out !== exps[i]) begin
                errors++; $display("FAIL sweep_op%0d: got %h want %h", i, out, exps[i]);
            end
`ifdef OVERFLOW_TRAP_EN
            if (i == 1) begin
                checks++;
                if (currState !== 2'b11) begin
                    errors++; $display("FAIL mul_trap_state: got %b want 11", currState);
                end
                step();
            end
`endif
        end
    endtask

    task automatic test_persist();
        num1 = 8'h07; num2 = 8'h02; in_sel = 3'b010; out_sel = 7'b1000000;
        step();
        step();
        checks++;
        if (out !== 8'h09) begin errors++; $display("FAIL load_add: got %h want 09", out); end
        in_sel = 3'b100; num1 = 8'hEE;
        step();
        step();
        checks++;
        if (out !== 8'h0B) begin errors++; $display("FAIL persist_add: got %h want 0b", out); end
    endtask

    task automatic test_invalid_sel();
        out_sel = 7'b0000011;
        step();
        checks++;
        if (nextState !== 2'b11) begin
            errors++; $display("FAIL invalid_next: got %b want 11", nextState);
        end
        step();
        checks++;
        if (currState !== 2'b11) begin
            errors++; $display("FAIL invalid_state: got %b want 11", currState);
        end
        checks++;
        if (out !== 8'h0B) begin errors++; $display("FAIL invalid_hold: got %h want 0b", out); end
        out_sel = 7'b0000000;
        #1;
        checks++;
        if (nextState !== 2'b01) begin
            errors++; $display("FAIL err_next: got %b want 01", nextState);
        end
        step();
        checks++;
        if (currState !== 2'b01) begin
            errors++; $display("FAIL err_to_load: got %b want 01", currState);
        end
    endtask

    task automatic test_clear_priority();
        in_sel = 3'b111; num1 = 8'h33; num2 = 8'h44; out_sel = 7'b0000001;
        step();
        step();
        checks++;
        if (out !== 8'hFF) begin errors++; $display("FAIL clear_not: got %h want ff", out); end
        in_sel = 3'b000; out_sel = 7'b1000000;
        step();
        step();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL hold_add: got %h want 00", out); end
    endtask

    task automatic test_on_drop();
        in_sel = 3'b010; num1 = 8'h10; num2 = 8'h01; out_sel = 7'b1000000;
        step();
        on = 1'b0;
        #1;
        checks++;
        if (nextState !== 2'b00) begin
            errors++; $display("FAIL drop_next: got %b want 00", nextState);
        end
        step();
        checks++;
        if (currState !== 2'b00) begin
            errors++; $display("FAIL drop_state: got %b want 00", currState);
        end
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL drop_discard: got %h want 00", out); end
        step();
        checks++;
        if (currState !== 2'b00 || out !== 8'h00) begin
            errors++; $display("FAIL off_hold: got %b/%h want 00/00", currState, out);
        end
        on = 1'b1;
        step();
        step();
        step();
        checks++;
        if (out !== 8'h11) begin errors++; $display("FAIL resume_add: got %h want 11", out); end
    endtask

    task automatic test_async_reset();
        step();
        checks++;
        if (currState !== 2'b10) begin
            errors++; $display("FAIL pre_rst_state: got %b want 10", currState);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL async_rst_out: got %h want 00", out); end
        checks++;
        if (currState !== 2'b00) begin
            errors++; $display("FAIL async_rst_state: got %b want 00", currState);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_op_sweep();
        test_persist();
        test_invalid_sel();
        test_clear_priority();
        test_on_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_alu.md
MAIN_ALU -- requirements
Module: main_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; all behaviour below assumes 8.
REQ-002 clk  input  1  single clock; all registers update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 on  input  1  enable; 0 forces FSM to OFF.
REQ-005 in_sel  input  3  register control: [2] persist, [1] load, [0] clear.
REQ-006 num1  input  WIDTH  operand A source.
REQ-007 num2  input  WIDTH  operand B source.
REQ-008 out_sel  input  7  one-hot operation select.
REQ-009 out  output  WIDTH  registered result (ACC).
REQ-010 currState  output  2  registered FSM state.
REQ-011 nextState  output  2  combinational next FSM state.

Function
REQ-012 Registers: A, B, ACC (WIDTH each); out SHALL equal ACC.
REQ-013 States: OFF=00, LOAD=01, EXEC=10, ERR=11.
REQ-014 Transitions: on=0 -> OFF from any state; OFF&on -> LOAD; LOAD -> EXEC; EXEC -> ERR if out_sel not exactly one-hot, else LOAD; ERR -> LOAD.
REQ-015 LOAD applies in_sel, priority clear > load > persist: clear A=B=0; load A=num1, B=num2; persist A=ACC, B=num2; 000 holds A, B.
REQ-016 EXEC writes ACC per out_sel: 1000000 A+B; 0100000 A-B; 0010000 low WIDTH bits of A*B; 0001000 A&B; 0000100 A|B; 0000010 A^B; 0000001 ~A.
REQ-017 Arithmetic wraps modulo 2^WIDTH (borrow/carry/high product bits discarded).
REQ-018 Invalid out_sel in EXEC: ACC holds, state goes ERR.
REQ-019 A, B, ACC hold in OFF and ERR; ACC changes only in EXEC.
REQ-020 Latency: operands sampled at LOAD edge; result on out after following EXEC edge (2 cycles from LOAD entry).
REQ-021 nextState SHALL reflect REQ-014 combinationally from currState, on, out_sel.
REQ-022 on dropping mid-operation: next edge enters OFF, pending EXEC result discarded, registers hold.

Reset
REQ-023 rst=1 asynchronously sets currState=OFF, A=B=ACC=0, out=0, independent of clk.
REQ-024 First LOAD occurs one edge after rst release with on=1.

Configuration
REQ-025 OVERFLOW_TRAP_EN defined: unsigned add carry-out, sub borrow, or nonzero high product bits in EXEC sets ACC=all ones and state goes ERR.
REQ-026 OVERFLOW_TRAP_EN undefined: wrap per REQ-017, no overflow-triggered ERR.

Verification
REQ-027 Reset, on=1, in_sel=010, num1=0x57, num2=0x1A, out_sel=1000000 -> out=0x71 after EXEC; currState sequence 00,01,10,01.
REQ-028 Same operands, out_sel sweep 0100000/0010000/0001000/0000100/0000010/0000001 -> 0x3D/0xD6/0x12/0x5F/0x4D/0xA8 (mul 0xFF and ERR with OVERFLOW_TRAP_EN).
REQ-029 num1=0x07, num2=0x02, add -> 0x09; then in_sel=100, num2=0x02, add -> 0x0B.
REQ-030 out_sel=0000011 in EXEC -> ACC holds, currState=11, then 01.
REQ-031 Assert rst between edges during EXEC -> out=0, currState=00 immediately; on=0 -> OFF next edge, out held.
